uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_if.sv | 30 +++
 rtl/uart_rx_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bus bundle for the UART receiver with its receive FIFO.
// The slave side is the receiver. The master side is whoever drives the serial
// line and drains the FIFO.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                 rx;
  logic                 rd_en;
  logic                 clear_err;
  logic [DATA_BITS-1:0] data;
  logic                 empty;
  logic                 full;
  logic [CW-1:0]        count;
  logic                 overrun;
  logic                 frame_err;
  logic                 parity_err;

  modport slave (
    input  rx, rd_en, clear_err,
    output data, empty, full, count, overrun, frame_err, parity_err
  );

  modport master (
    output rx, rd_en, clear_err,
    input  data, empty, full, count, overrun, frame_err, parity_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with a first-word-fall-through receive FIFO.
// The rx input is synchronised through two flops. A falling edge starts a frame.
// Each bit is sampled at its midpoint. Good frames are pushed into the FIFO.
// Overrun, framing and parity errors are held in sticky flags.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 2083,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_fifo_if.slave   bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] HALF_BIT   = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_BIT_M = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_BITS - 1);
  localparam logic [CW-1:0]    FULL_CNT   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // Returns 1 when the received parity bit disagrees with the configured sense.
  // Even parity means XOR over data and parity is 0. Odd parity means it is 1.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    logic want;
    want = (PARITY == 1);
    return ((^d) ^ p) != want;
  endfunction

  // Synchroniser and previous-sample registers
  logic rx_meta_q, rx_sync_q, rx_last_q;

  // Receiver state
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BIT_W-1:0] bit_q;
  logic             bad_q;
  logic             wr_q;
  logic             perr_ev_q;
  logic             ferr_ev_q;
  logic [DATA_BITS-1:0] shreg_q;

  // FIFO storage and control
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [CW-1:0]        count_q;
  logic                 overrun_q, frame_err_q, parity_err_q;

  logic empty, full, pop, push_ok, ovr_ev, shift_en;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign pop      = bus.rd_en && !empty;
  assign push_ok  = wr_q && (!full || pop);
  assign ovr_ev   = wr_q && full && !pop;
  assign shift_en = (state_q == S_DATA) && (cnt_q == '0);

  // Two-flop synchroniser plus one extra stage used for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_last_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
      rx_last_q <= rx_sync_q;
    end
  end

  // Receiver FSM. The write strobe and the error events are registered pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      bad_q     <= 1'b0;
      wr_q      <= 1'b0;
      perr_ev_q <= 1'b0;
      ferr_ev_q <= 1'b0;
    end else begin
      wr_q      <= 1'b0;
      perr_ev_q <= 1'b0;
      ferr_ev_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (rx_last_q && !rx_sync_q) begin
            state_q <= S_START;
            cnt_q   <= HALF_BIT;
            bad_q   <= 1'b0;
          end
        end
        S_START: begin
          if (cnt_q == '0) begin
            // A line that is high again at the start-bit midpoint was a glitch
            if (rx_sync_q) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DATA;
              cnt_q   <= FULL_BIT_M;
              bit_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            cnt_q <= FULL_BIT_M;
            if (bit_q == LAST_BIT) begin
              state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt_q == '0) begin
            cnt_q   <= FULL_BIT_M;
            state_q <= S_STOP;
            if (parity_bad(shreg_q, rx_sync_q)) begin
              bad_q     <= 1'b1;
              perr_ev_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == '0) begin
            if (!rx_sync_q) begin
              ferr_ev_q <= 1'b1;
              state_q   <= S_WAIT_IDLE;
            end else begin
              wr_q    <= !bad_q;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (rx_sync_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Data shift register. It takes bits LSB first and stays stable until the next
  // frame, so the FIFO write can read it directly.
  always_ff @(posedge clk) begin
    if (shift_en) shreg_q <= {rx_sync_q, shreg_q[DATA_BITS-1:1]};
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= shreg_q;
  end

  // FIFO pointers and occupancy count. The pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop)     rptr_q <= rptr_q + AW'(1);
      if (push_ok && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push_ok) count_q <= count_q - CW'(1);
    end
  end

  // Sticky error flags. An error event wins over clear_err in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      overrun_q    <= (overrun_q    && !bus.clear_err) || ovr_ev;
      frame_err_q  <= (frame_err_q  && !bus.clear_err) || ferr_ev_q;
      parity_err_q <= (parity_err_q && !bus.clear_err) || perr_ev_q;
    end
  end

  assign bus.data       = empty ? '0 : mem_q[rptr_q];
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.count      = count_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo.
// Instance A has no parity and instance B has even parity. Both use 16 clks per
// bit, 8 data bits and a 4-entry FIFO. One serial line is steered to either instance.
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic rx_line;
  logic sel_b;
  logic rd_a, rd_b, clr_a, clr_b;

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifa ();
  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifb ();

  assign ifa.rx        = sel_b ? 1'b1 : rx_line;
  assign ifb.rx        = sel_b ? rx_line : 1'b1;
  assign ifa.rd_en     = rd_a;
  assign ifb.rd_en     = rd_b;
  assign ifa.clear_err = clr_a;
  assign ifb.clear_err = clr_b;

  uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges, then step 1ns past the edge for driving and sampling
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send one frame: start bit, 8 data bits LSB first, an optional parity bit
  // and a stop bit. The line returns to idle at the end.
  task automatic send_frame(input logic sel, input logic [7:0] d, input logic use_par,
                            input logic par, input logic stop);
    sel_b   = sel;
    rx_line = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      tick(16);
    end
    if (use_par) begin
      rx_line = par;
      tick(16);
    end
    rx_line = stop;
    tick(16);
    rx_line = 1'b1;
  endtask

  task automatic pop_a();
    rd_a = 1'b1;
    tick(1);
    rd_a = 1'b0;
  endtask

  logic [7:0] exp_seq [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b1;
    rx_line = 1'b1;
    sel_b   = 1'b0;
    rd_a    = 1'b0;
    rd_b    = 1'b0;
    clr_a   = 1'b0;
    clr_b   = 1'b0;
    exp_seq[0] = 8'h01;
    exp_seq[1] = 8'h02;
    exp_seq[2] = 8'h03;
    exp_seq[3] = 8'h04;
    tick(3);

    // Values while reset is held
    chk("rst_empty", 32'(ifa.empty), 32'd1);
    chk("rst_full", 32'(ifa.full), 32'd0);
    chk("rst_count", 32'(ifa.count), 32'd0);
    chk("rst_data", 32'(ifa.data), 32'd0);
    chk("rst_flags", {29'd0, ifa.overrun, ifa.frame_err, ifa.parity_err}, 32'd0);
    chk("rst_b_empty", 32'(ifb.empty), 32'd1);
    reset = 1'b0;
    tick(5);

    // One good frame is received, then popped
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    chk("a5_empty", 32'(ifa.empty), 32'd0);
    chk("a5_count", 32'(ifa.count), 32'd1);
    chk("a5_data", 32'(ifa.data), 32'hA5);
    pop_a();
    chk("a5_pop_empty", 32'(ifa.empty), 32'd1);
    chk("a5_pop_count", 32'(ifa.count), 32'd0);
    tick(8);

    // A short low glitch is not a start bit
    rx_line = 1'b0;
    tick(4);
    rx_line = 1'b1;
    tick(40);
    chk("glitch_count", 32'(ifa.count), 32'd0);
    chk("glitch_flags", {29'd0, ifa.overrun, ifa.frame_err, ifa.parity_err}, 32'd0);

    // Framing error, then a good frame; the flag stays until cleared
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    tick(4);
    chk("ferr_flag", 32'(ifa.frame_err), 32'd1);
    chk("ferr_count", 32'(ifa.count), 32'd0);
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    chk("ferr_next_data", 32'(ifa.data), 32'h11);
    chk("ferr_sticky", 32'(ifa.frame_err), 32'd1);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    chk("ferr_cleared", 32'(ifa.frame_err), 32'd0);
    tick(8);

    // Even parity on instance B: a wrong parity bit is rejected, the right one is accepted
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    tick(4);
    chk("perr_flag", 32'(ifb.parity_err), 32'd1);
    chk("perr_count", 32'(ifb.count), 32'd0);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    chk("par_ok_data", 32'(ifb.data), 32'h07);
    chk("par_ok_count", 32'(ifb.count), 32'd1);
    sel_b = 1'b0;
    tick(8);

    // Drain 0x11 from A, then overfill the FIFO
    pop_a();
    chk("drain_empty", 32'(ifa.empty), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
      tick(4);
    end
    chk("ovf_full", 32'(ifa.full), 32'd1);
    chk("ovf_count", 32'(ifa.count), 32'd4);
    chk("ovf_flag", 32'(ifa.overrun), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_order%0d", i), 32'(ifa.data), 32'(exp_seq[i]));
      pop_a();
    end
    chk("ovf_drained", 32'(ifa.empty), 32'd1);

    // A pop on an empty FIFO is ignored
    pop_a();
    chk("empty_pop_count", 32'(ifa.count), 32'd0);
    chk("empty_pop_empty", 32'(ifa.empty), 32'd1);
    chk("empty_pop_ovr", 32'(ifa.overrun), 32'd1);
    tick(8);

    // Reset in the middle of data bit 3 of 0xFF, then a clean 0x5A frame
    sel_b   = 1'b0;
    rx_line = 1'b0;
    tick(16);
    for (int i = 0; i < 3; i++) begin
      rx_line = 1'b1;
      tick(16);
    end
    rx_line = 1'b1;
    tick(8);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(8 + 16 * 5);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    tick(4);
    chk("midrst_count", 32'(ifa.count), 32'd1);
    chk("midrst_data", 32'(ifa.data), 32'h5A);
    chk("midrst_flags", {29'd0, ifa.overrun, ifa.frame_err, ifa.parity_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
